fetch_controller: RTL and testbench
===================================

// Module: fetch_controller
// PURPOSE
//   Sequences instruction fetch between the instruction memory and the fetch
//   stage. Owns the word-addressed fetch PC and issues req/ack memory reads.
//   Delivers each returned instruction with its PC, holding it while decode
//   stalls. Applies branch and exception redirects and drives the fetch
//   stage's write_pc/pc inputs and the pipeline flush.
// PARAMETERS
//   RESET_PC  32'h0  fetch address used after reset
//   MAX_WAIT  15     cycles a request may wait for ack before FAULT (1..255)
// PORTS
//   clk              in   1   clock, all state updates on posedge
//   rst_n            in   1   asynchronous active-low reset
//   stall_i          in   1   decode cannot accept an instruction this cycle
//   branch_valid_i   in   1   branch redirect request (single-cycle pulse)
//   branch_target_i  in   32  branch target word address
//   exc_valid_i      in   1   exception redirect request (single-cycle pulse)
//   exc_vector_i     in   32  exception vector word address
//   imem_req_o       out  1   memory read request
//   imem_addr_o      out  32  memory read address, stable while req && !ack
//   imem_ack_i       in   1   memory read complete, imem_data_i valid
//   imem_data_i      in   32  read data
//   instr_valid_o    out  1   instr_o/pc_o hold a valid instruction
//   instr_o          out  32  delivered instruction
//   pc_o             out  32  PC of instr_o; redirect target when write_pc_o=1
//   write_pc_o       out  1   one-cycle pulse: fetch stage loads pc_o
//   flush_o          out  1   one-cycle pulse: younger pipeline work is killed
//   fault_o          out  1   sticky fetch timeout indication
// BEHAVIOUR
//   Reset (async, rst_n=0): state BOOT, fetch_pc=RESET_PC. All outputs are 0,
//     except pc_o=RESET_PC. The wait counter and discard flag clear.
//   All outputs are registered. An instruction appears on instr_valid_o/instr_o/
//     pc_o exactly 1 cycle after the ack that returned it.
//   States:
//   BOOT: req=0. Pulse write_pc_o with pc_o=RESET_PC, then go to WAIT.
//   WAIT: req=1, addr=fetch_pc. On ack with discard=0:
//     stall_i=0 -> deliver for one cycle, fetch_pc+=1, stay in WAIT.
//       Next-cycle addr=fetch_pc+1, so back-to-back acks give 1 instr/cycle.
//     stall_i=1 -> latch data and PC, go to HOLD.
//   HOLD: req=0, instr_valid_o=1, outputs frozen. When stall_i=0, the
//     instruction is consumed; fetch_pc+=1; go to WAIT.
//   FAULT: req=0, fault_o=1. Leaves only on exc_valid_i (-> WAIT at the
//     vector) or on reset.
//   Redirect: exception beats branch when both occur in the same cycle.
//     In BOOT, WAIT or HOLD, a redirect sets fetch_pc=target and
//     drops any held instruction (instr_valid_o=0 next cycle). It pulses
//     flush_o and write_pc_o with pc_o=target for one cycle.
//     In FAULT, branch_valid_i is ignored.
//   Outstanding request at redirect (req=1, no ack that cycle):
//     req cannot be withdrawn, so set discard=1 and keep the old addr until
//     ack. The ack data is dropped and discard clears. The next request
//     uses the target.
//   Ack in the same cycle as redirect: the data is dropped and the next
//     request uses the target. No discard is needed.
//   Ack seen while discard=1 with stall_i=1: the data is dropped and the
//     state stays WAIT.
//   Timeout: the counter increments on each WAIT cycle with req && !ack, and
//     clears on ack or redirect. When count==MAX_WAIT -> FAULT, req drops.
//     If exc_valid_i arrives in that same cycle, the exception wins (-> WAIT).
//   Wrap: fetch_pc increments modulo 2^32 (32'hFFFFFFFF -> 0) with no flag.
//   Asserting stall_i with no valid instruction has no effect.
// TESTING
//   1 reset, ack tied high, data=addr -> write_pc_o@pc 0, then
//     instr 0,1,2,3 on consecutive cycles with pc_o matching.
//   2 ack on pc 5 with stall_i=1 for 3 cycles -> instr 5 held 3 cycles,
//     req=0, then pc 6 requested.
//   3 branch_valid_i target 0x40 while the req for pc 7 waits 2 cycles ->
//     flush_o=1 and write_pc_o=1 with pc_o=0x40; ack for 7 is dropped;
//     next addr is 0x40.
//   4 branch 0x40 and exc 0x100 in the same cycle -> pc_o=0x100,
//     fetch continues at 0x100.
//   5 no ack for MAX_WAIT cycles -> fault_o=1, req=0. Then exc 0x200 ->
//     flush_o pulses, req addr=0x200, fault_o stays 1 until reset.
//   6 RESET_PC=32'hFFFFFFFF, ack high -> pcs FFFFFFFF,0,1; rst_n low
//     mid-request -> all outputs 0 immediately.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the word-addressed fetch PC, issues req/ack
// memory reads, delivers instructions with their PC and applies redirects.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        branch_valid_i,
  input  logic [31:0] branch_target_i,
  input  logic        exc_valid_i,
  input  logic [31:0] exc_vector_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        write_pc_o,
  output logic        flush_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {BOOT, WAIT, HOLD, FAULT} state_e;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        discard_q, discard_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        write_pc_q, write_pc_d;
  logic        flush_q, flush_d;
  logic        fault_q, fault_d;

  logic        redirect;
  logic [31:0] target;

  always_comb begin
    target     = exc_valid_i ? exc_vector_i : branch_target_i;
    redirect   = exc_valid_i || (branch_valid_i && (state_q != FAULT));
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    wait_cnt_d = wait_cnt_q;
    discard_d  = discard_q;
    valid_d    = 1'b0;
    instr_d    = instr_q;
    pc_d       = pc_q;
    write_pc_d = 1'b0;
    flush_d    = 1'b0;
    fault_d    = fault_q;

    if (redirect) begin
      // A request already on the bus cannot be withdrawn; its ack is dropped later.
      state_d    = WAIT;
      fetch_pc_d = target;
      wait_cnt_d = 8'd0;
      discard_d  = (state_q == WAIT) && !imem_ack_i;
      pc_d       = target;
      write_pc_d = 1'b1;
      flush_d    = 1'b1;
    end else begin
      unique case (state_q)
        BOOT: begin
          state_d    = WAIT;
          pc_d       = RESET_PC;
          write_pc_d = 1'b1;
        end
        WAIT: begin
          if (imem_ack_i) begin
            wait_cnt_d = 8'd0;
            if (discard_q) begin
              discard_d = 1'b0;
            end else begin
              valid_d = 1'b1;
              instr_d = imem_data_i;
              pc_d    = fetch_pc_q;
              if (stall_i) state_d = HOLD;
              else         fetch_pc_d = fetch_pc_q + 32'd1;
            end
          end else if (wait_cnt_q == LAST_WAIT) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            discard_d  = 1'b0;
            wait_cnt_d = 8'd0;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
        HOLD: begin
          valid_d = 1'b1;
          if (!stall_i) begin
            valid_d    = 1'b0;
            state_d    = WAIT;
            fetch_pc_d = fetch_pc_q + 32'd1;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end

    req_d  = (state_d == WAIT);
    addr_d = discard_d ? addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      wait_cnt_q <= 8'd0;
      discard_q  <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= 32'd0;
      valid_q    <= 1'b0;
      instr_q    <= 32'd0;
      pc_q       <= RESET_PC;
      write_pc_q <= 1'b0;
      flush_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wait_cnt_q <= wait_cnt_d;
      discard_q  <= discard_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      write_pc_q <= write_pc_d;
      flush_q    <= flush_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign write_pc_o    = write_pc_q;
  assign flush_o       = flush_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed vector table, hand-written fault/wrap/reset
// sequences and a randomized run against a behavioural fetch model.
module tb_fetch_controller;

  localparam logic [31:0] RPC  = 32'h0;
  localparam int          MW   = 6;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        wpc;
    logic        flush;
    logic        fault;
  } outs_t;

  typedef struct {
    logic        s;
    logic        b;
    logic [31:0] bt;
    logic        e;
    logic [31:0] ev;
    logic        a;
    logic [31:0] d;
    outs_t       exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, br_v, exc_v, ack;
  logic [31:0] br_t, exc_vec, data;
  logic        req, valid, wpc, flush, fault;
  logic [31:0] addr, instr, pc;

  logic        rst_n2;
  logic        req2, valid2, wpc2, flush2, fault2;
  logic [31:0] addr2, instr2, pc2;

  int checkCount = 0;
  int passCount  = 0;

  fetch_controller #(.RESET_PC(RPC), .MAX_WAIT(MW)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall),
    .branch_valid_i(br_v), .branch_target_i(br_t),
    .exc_valid_i(exc_v), .exc_vector_i(exc_vec),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_data_i(data),
    .instr_valid_o(valid), .instr_o(instr), .pc_o(pc),
    .write_pc_o(wpc), .flush_o(flush), .fault_o(fault)
  );

  // Second instance: memory always acks and returns the address as data.
  fetch_controller #(.RESET_PC(RPC2), .MAX_WAIT(15)) u_dut2 (
    .clk(clk), .rst_n(rst_n2), .stall_i(1'b0),
    .branch_valid_i(1'b0), .branch_target_i(32'd0),
    .exc_valid_i(1'b0), .exc_vector_i(32'd0),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_ack_i(1'b1), .imem_data_i(addr2),
    .instr_valid_o(valid2), .instr_o(instr2), .pc_o(pc2),
    .write_pc_o(wpc2), .flush_o(flush2), .fault_o(fault2)
  );

  function automatic outs_t mkOut(input logic rq, input logic [31:0] ad, input logic vl,
                                  input logic [31:0] in, input logic [31:0] p,
                                  input logic w, input logic f, input logic ft);
    outs_t o;
    o.req = rq; o.addr = ad; o.valid = vl; o.instr = in; o.pc = p;
    o.wpc = w; o.flush = f; o.fault = ft;
    return o;
  endfunction

  function automatic vec_t row(input logic s, input logic b, input logic [31:0] bt,
                               input logic e, input logic [31:0] ev, input logic a,
                               input logic [31:0] d, input logic rq, input logic [31:0] ad,
                               input logic vl, input logic [31:0] in, input logic [31:0] p,
                               input logic w, input logic f);
    vec_t r;
    r.s = s; r.b = b; r.bt = bt; r.e = e; r.ev = ev; r.a = a; r.d = d;
    r.exp = mkOut(rq, ad, vl, in, p, w, f, 1'b0);
    return r;
  endfunction

  task automatic applyStimulus(input logic s, input logic b, input logic [31:0] bt,
                               input logic e, input logic [31:0] ev, input logic a,
                               input logic [31:0] d);
    stall = s; br_v = b; br_t = bt; exc_v = e; exc_vec = ev; ack = a; data = d;
    @(posedge clk);
    #1;
  endtask

  // Address only matters while requesting, instr while valid, pc while valid or loading.
  task automatic checkOutput(input string name, input int idx, input outs_t act,
                             input outs_t exp, input bit strict);
    bit bad;
    bad = (act.req !== exp.req) || (act.valid !== exp.valid) || (act.wpc !== exp.wpc) ||
          (act.flush !== exp.flush) || (act.fault !== exp.fault);
    if (strict || exp.req) bad = bad || (act.addr !== exp.addr);
    if (strict || exp.valid) bad = bad || (act.instr !== exp.instr);
    if (strict || exp.valid || exp.wpc) bad = bad || (act.pc !== exp.pc);
    checkCount++;
    if (bad)
      $display("[TB] FAIL %s #%0d: got req=%b addr=%h valid=%b instr=%h pc=%h wpc=%b flush=%b fault=%b; want req=%b addr=%h valid=%b instr=%h pc=%h wpc=%b flush=%b fault=%b",
               name, idx, act.req, act.addr, act.valid, act.instr, act.pc, act.wpc, act.flush, act.fault,
               exp.req, exp.addr, exp.valid, exp.instr, exp.pc, exp.wpc, exp.flush, exp.fault);
    else
      passCount++;
  endtask

  function automatic outs_t dutOut();
    return outs_t'({req, addr, valid, instr, pc, wpc, flush, fault});
  endfunction

  function automatic outs_t dut2Out();
    return outs_t'({req2, addr2, valid2, instr2, pc2, wpc2, flush2, fault2});
  endfunction

  // Behavioural model: tracks whether fetch is booting, holding or faulted,
  // the next fetch address and whether the outstanding reply must be dropped.
  bit          mBoot, mHeld, mFaultSt, mDrop;
  logic [31:0] mPc;
  int          mIdle;
  outs_t       e;

  task automatic modelReset();
    mBoot = 1; mHeld = 0; mFaultSt = 0; mDrop = 0; mPc = RPC; mIdle = 0;
    e = '0;
    e.pc = RPC;
  endtask

  task automatic modelStep(input logic s, input logic b, input logic [31:0] bt,
                           input logic ex, input logic [31:0] ev, input logic a,
                           input logic [31:0] d);
    bit waiting, redir;
    waiting = e.req;
    redir   = ex || (b && !mFaultSt);
    e.wpc   = 0;
    e.flush = 0;
    e.valid = mHeld;
    if (redir) begin
      mDrop = waiting && !a;
      mPc = ex ? ev : bt;
      mBoot = 0; mHeld = 0; mFaultSt = 0; mIdle = 0;
      e.valid = 0; e.wpc = 1; e.flush = 1; e.pc = mPc;
    end else if (mBoot) begin
      mBoot = 0; e.wpc = 1; e.pc = RPC;
    end else if (mHeld) begin
      if (!s) begin
        mHeld = 0; e.valid = 0; mPc = mPc + 1;
      end
    end else if (waiting) begin
      if (a) begin
        mIdle = 0;
        if (mDrop) mDrop = 0;
        else begin
          e.valid = 1; e.instr = d; e.pc = mPc;
          if (s) mHeld = 1;
          else   mPc = mPc + 1;
        end
      end else begin
        mIdle++;
        if (mIdle == MW) begin
          mFaultSt = 1; e.fault = 1; mDrop = 0; mIdle = 0;
        end
      end
    end
    e.req = !mBoot && !mHeld && !mFaultSt;
    if (!mDrop) e.addr = mPc;
  endtask

  vec_t vecs[$];

  initial begin
    outs_t x;
    logic rs, rb, re, ra;
    logic [31:0] rbt, rev, rd;

    rst_n = 0; rst_n2 = 0;
    stall = 0; br_v = 0; br_t = 0; exc_v = 0; exc_vec = 0; ack = 0; data = 0;

    vecs.push_back(row(0,0,0,      0,0,      0,0,         1,32'h0,  0,0,         32'h0,  1,0));
    vecs.push_back(row(0,0,0,      0,0,      1,32'h0,     1,32'h1,  1,32'h0,     32'h0,  0,0));
    vecs.push_back(row(0,0,0,      0,0,      1,32'h1,     1,32'h2,  1,32'h1,     32'h1,  0,0));
    vecs.push_back(row(0,0,0,      0,0,      1,32'h2,     1,32'h3,  1,32'h2,     32'h2,  0,0));
    vecs.push_back(row(0,0,0,      0,0,      1,32'h3,     1,32'h4,  1,32'h3,     32'h3,  0,0));
    vecs.push_back(row(0,0,0,      0,0,      1,32'h4,     1,32'h5,  1,32'h4,     32'h4,  0,0));
    vecs.push_back(row(1,0,0,      0,0,      1,32'h55,    0,32'h5,  1,32'h55,    32'h5,  0,0));
    vecs.push_back(row(1,0,0,      0,0,      1,32'h99,    0,32'h5,  1,32'h55,    32'h5,  0,0));
    vecs.push_back(row(1,0,0,      0,0,      0,0,         0,32'h5,  1,32'h55,    32'h5,  0,0));
    vecs.push_back(row(0,0,0,      0,0,      0,0,         1,32'h6,  0,0,         0,      0,0));
    vecs.push_back(row(0,0,0,      0,0,      1,32'h66,    1,32'h7,  1,32'h66,    32'h6,  0,0));
    vecs.push_back(row(0,0,0,      0,0,      0,0,         1,32'h7,  0,0,         0,      0,0));
    vecs.push_back(row(0,0,0,      0,0,      0,0,         1,32'h7,  0,0,         0,      0,0));
    vecs.push_back(row(0,1,32'h40, 0,0,      0,0,         1,32'h7,  0,0,         32'h40, 1,1));
    vecs.push_back(row(0,0,0,      0,0,      1,32'h77,    1,32'h40, 0,0,         0,      0,0));
    vecs.push_back(row(0,0,0,      0,0,      1,32'h1040,  1,32'h41, 1,32'h1040,  32'h40, 0,0));
    vecs.push_back(row(0,1,32'h40, 1,32'h100,1,32'h1041,  1,32'h100,0,0,         32'h100,1,1));
    vecs.push_back(row(0,0,0,      0,0,      1,32'h2100,  1,32'h101,1,32'h2100,  32'h100,0,0));
    vecs.push_back(row(1,0,0,      0,0,      1,32'h2101,  0,0,      1,32'h2101,  32'h101,0,0));
    vecs.push_back(row(1,0,0,      1,32'h300,0,0,         1,32'h300,0,0,         32'h300,1,1));
    vecs.push_back(row(0,0,0,      0,0,      1,32'h3300,  1,32'h301,1,32'h3300,  32'h300,0,0));
    vecs.push_back(row(1,0,0,      0,0,      0,0,         1,32'h301,0,0,         0,      0,0));

    #12;
    checkOutput("reset", 0, dutOut(), mkOut(0,0,0,0,RPC,0,0,0), 1);
    checkOutput("reset2", 0, dut2Out(), mkOut(0,0,0,0,RPC2,0,0,0), 1);

    @(negedge clk);
    rst_n = 1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s, vecs[i].b, vecs[i].bt, vecs[i].e, vecs[i].ev, vecs[i].a, vecs[i].d);
      checkOutput("table", i, dutOut(), vecs[i].exp, 0);
    end

    // Timeout: counter restarts on an ack, then MW silent cycles raise fault.
    applyStimulus(0,0,0,0,0,1,32'hABCD);
    checkOutput("pre_fault_ack", 0, dutOut(), mkOut(1,32'h302,1,32'hABCD,32'h301,0,0,0), 0);
    for (int i = 1; i <= MW; i++) begin
      applyStimulus(0,0,0,0,0,0,0);
      checkOutput("timeout", i, dutOut(), mkOut(i < MW, 32'h302, 0, 0, 0, 0, 0, i == MW), 0);
    end
    applyStimulus(0,1,32'h40,0,0,0,0);
    checkOutput("fault_ignores_branch", 0, dutOut(), mkOut(0,0,0,0,0,0,0,1), 0);
    applyStimulus(0,0,0,0,0,1,32'h1);
    checkOutput("fault_idle", 0, dutOut(), mkOut(0,0,0,0,0,0,0,1), 0);
    applyStimulus(0,0,0,1,32'h200,0,0);
    checkOutput("fault_exc", 0, dutOut(), mkOut(1,32'h200,0,0,32'h200,1,1,1), 0);
    applyStimulus(0,0,0,0,0,1,32'h5200);
    checkOutput("after_fault", 0, dutOut(), mkOut(1,32'h201,1,32'h5200,32'h200,0,0,1), 0);

    #2 rst_n = 0;
    #1 checkOutput("async_reset", 0, dutOut(), mkOut(0,0,0,0,RPC,0,0,0), 1);

    // Wrap from the top of the address space, then reset mid-request.
    @(negedge clk);
    rst_n2 = 1;
    @(posedge clk); #1;
    checkOutput("wrap_boot", 0, dut2Out(), mkOut(1,32'hFFFF_FFFF,0,0,32'hFFFF_FFFF,1,0,0), 0);
    @(posedge clk); #1;
    checkOutput("wrap", 1, dut2Out(), mkOut(1,32'h0,1,32'hFFFF_FFFF,32'hFFFF_FFFF,0,0,0), 0);
    @(posedge clk); #1;
    checkOutput("wrap", 2, dut2Out(), mkOut(1,32'h1,1,32'h0,32'h0,0,0,0), 0);
    @(posedge clk); #1;
    checkOutput("wrap", 3, dut2Out(), mkOut(1,32'h2,1,32'h1,32'h1,0,0,0), 0);
    #2 rst_n2 = 0;
    #1 checkOutput("async_reset2", 0, dut2Out(), mkOut(0,0,0,0,RPC2,0,0,0), 1);

    stall = 0; br_v = 0; exc_v = 0; ack = 0;
    @(negedge clk);
    rst_n = 1;
    modelReset();
    for (int n = 0; n < 3000; n++) begin
      rs  = ($urandom_range(0, 9) < 3);
      rb  = ($urandom_range(0, 99) < 6);
      re  = ($urandom_range(0, 99) < 3);
      ra  = ($urandom_range(0, 99) < 55);
      rbt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
      rev = {$urandom_range(0, 255), 4'h0};
      rd  = $urandom;
      modelStep(rs, rb, rbt, re, rev, ra, rd);
      applyStimulus(rs, rb, rbt, re, rev, ra, rd);
      x = dutOut();
      checkOutput("random", n, x, e, 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
